// File: rtl/rf_exec_seq.sv
// Register-file execute sequencer: IDLE -> READ -> EXEC -> WB.
// Ports: instr_* handshake in; ra1/ra2 reads, rd1/rd2 data; en/wa/wd write; done; carry.
module rf_exec_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [2:0]  instr_op,
  input  logic [3:0]  instr_rd,
  input  logic [3:0]  instr_rs1,
  input  logic [3:0]  instr_rs2,
  output logic [3:0]  ra1,
  output logic [3:0]  ra2,
  input  logic [15:0] rd1,
  input  logic [15:0] rd2,
  output logic        en,
  output logic [3:0]  wa,
  output logic [15:0] wd,
  output logic        done,
  output logic        carry
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    EXEC = 2'd2,
    WB   = 2'd3
  } state_e;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  state_e      state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [3:0]  rd_q, rd_d;
  logic [3:0]  ra1_q, ra1_d;
  logic [3:0]  ra2_q, ra2_d;
  logic [15:0] a_q, a_d;
  logic [15:0] b_q, b_d;
  logic [15:0] acc_q, acc_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  wa_q, wa_d;
  logic [15:0] wd_q, wd_d;
  logic        carry_q, carry_d;

  logic [16:0] sum;
  logic [15:0] alu;
  logic [15:0] mac;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= '0;
      rd_q    <= '0;
      ra1_q   <= '0;
      ra2_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      wa_q    <= '0;
      wd_q    <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      ra1_q   <= ra1_d;
      ra2_q   <= ra2_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      wa_q    <= wa_d;
      wd_q    <= wd_d;
      carry_q <= carry_d;
    end
  end

  always_comb begin
    sum = {1'b0, a_q} + {1'b0, b_q};
    alu = '0;
    unique case (op_q)
      OP_ADD:  alu = sum[15:0];
      OP_SUB:  alu = a_q - b_q;
      OP_AND:  alu = a_q & b_q;
      OP_OR:   alu = a_q | b_q;
      OP_XOR:  alu = a_q ^ b_q;
      OP_SHL:  alu = a_q << b_q[3:0];
      OP_SHR:  alu = a_q >> b_q[3:0];
      default: alu = '0;
    endcase
    // One shift-add step of the multiplier.
    mac = b_q[0] ? (acc_q + a_q) : acc_q;
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    rd_d    = rd_q;
    ra1_d   = ra1_q;
    ra2_d   = ra2_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    wa_d    = wa_q;
    wd_d    = wd_q;
    carry_d = carry_q;
    unique case (state_q)
      IDLE: begin
        if (instr_valid) begin
          op_d    = instr_op;
          rd_d    = instr_rd;
          ra1_d   = instr_rs1;
          ra2_d   = instr_rs2;
          state_d = READ;
        end
      end
      READ: begin
        a_d     = rd1;
        b_d     = rd2;
        acc_d   = '0;
        cnt_d   = '0;
        state_d = EXEC;
      end
      EXEC: begin
        if (op_q == OP_MUL) begin
          acc_d = mac;
          a_d   = a_q << 1;
          b_d   = b_q >> 1;
          cnt_d = cnt_q + 4'd1;
          // Counter wraps to 0 after the 16th step.
          if (cnt_q == 4'd15) begin
            wa_d    = rd_q;
            wd_d    = mac;
            state_d = WB;
          end
        end else begin
          wa_d = rd_q;
          wd_d = alu;
          if (op_q == OP_ADD) carry_d = sum[16];
          if (op_q == OP_SUB) carry_d = (a_q < b_q);
          state_d = WB;
        end
      end
      WB: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign instr_ready = (state_q == IDLE);
  assign en          = (state_q == WB);
  assign done        = (state_q == WB);
  assign ra1         = ra1_q;
  assign ra2         = ra2_q;
  assign wa          = wa_q;
  assign wd          = wd_q;
  assign carry       = carry_q;

endmodule

// File: tb/tb_rf_exec_seq.sv
// Directed bench for rf_exec_seq with a behavioural register file.
// Checks latency, results, carry, handshake and reset abort.
module tb_rf_exec_seq;

  logic        clk;
  logic        rst_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [2:0]  instr_op;
  logic [3:0]  instr_rd;
  logic [3:0]  instr_rs1;
  logic [3:0]  instr_rs2;
  logic [3:0]  ra1;
  logic [3:0]  ra2;
  logic [15:0] rd1;
  logic [15:0] rd2;
  logic        en;
  logic [3:0]  wa;
  logic [15:0] wd;
  logic        done;
  logic        carry;

  logic [15:0] rf [16];
  logic        pl_en;
  logic [3:0]  pl_a;
  logic [15:0] pl_d;

  int checks = 0;
  int errors = 0;

  rf_exec_seq dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr_op    (instr_op),
    .instr_rd    (instr_rd),
    .instr_rs1   (instr_rs1),
    .instr_rs2   (instr_rs2),
    .ra1         (ra1),
    .ra2         (ra2),
    .rd1         (rd1),
    .rd2         (rd2),
    .en          (en),
    .wa          (wa),
    .wd          (wd),
    .done        (done),
    .carry       (carry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign rd1 = rf[ra1];
  assign rd2 = rf[ra2];

  always @(posedge clk) begin
    if (en) rf[wa] <= wd;
    else if (pl_en) rf[pl_a] <= pl_d;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [3:0] a, input logic [15:0] d);
    @(negedge clk);
    pl_en = 1'b1;
    pl_a  = a;
    pl_d  = d;
    @(posedge clk);
    #1 pl_en = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [2:0] op,
                        input logic [3:0] rd, input logic [3:0] rs1,
                        input logic [3:0] rs2, input logic [15:0] exp_wd,
                        input int exp_lat, input logic exp_c);
    int n;
    @(negedge clk);
    chk({tag, "_ready"}, instr_ready, 1);
    instr_valid = 1'b1;
    instr_op    = op;
    instr_rd    = rd;
    instr_rs1   = rs1;
    instr_rs2   = rs2;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        chk({tag, "_ra1"}, ra1, rs1);
        chk({tag, "_ra2"}, ra2, rs2);
      end
      if (en) break;
    end
    chk({tag, "_lat"}, n, exp_lat);
    chk({tag, "_wa"}, wa, rd);
    chk({tag, "_wd"}, wd, exp_wd);
    chk({tag, "_done"}, done, 1);
    @(posedge clk);
    #1;
    chk({tag, "_carry"}, carry, exp_c);
    chk({tag, "_rf"}, rf[rd], exp_wd);
    chk({tag, "_en_off"}, en, 0);
  endtask

  initial begin
    int n;
    int seen;
    rst_n       = 1'b0;
    instr_valid = 1'b0;
    instr_op    = '0;
    instr_rd    = '0;
    instr_rs1   = '0;
    instr_rs2   = '0;
    pl_en       = 1'b0;
    pl_a        = '0;
    pl_d        = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", instr_ready, 1);
    chk("rst_en", en, 0);
    chk("rst_done", done, 0);
    chk("rst_carry", carry, 0);
    chk("rst_ra1", ra1, 0);
    chk("rst_ra2", ra2, 0);
    chk("rst_wa", wa, 0);
    chk("rst_wd", wd, 0);
    rst_n = 1'b1;

    preload(3, 16'd23);
    preload(5, 16'd53);
    run_op("add", 3'b000, 7, 3, 5, 16'd76, 3, 1'b0);

    preload(1, 16'hFFFF);
    preload(2, 16'h0001);
    run_op("add_c", 3'b000, 1, 1, 2, 16'h0000, 3, 1'b1);
    run_op("sub", 3'b001, 4, 2, 1, 16'h0001, 3, 1'b0);

    preload(10, 16'd5);
    preload(11, 16'd9);
    run_op("sub_b", 3'b001, 14, 10, 11, 16'hFFFC, 3, 1'b1);
    run_op("and", 3'b010, 14, 10, 11, 16'h0001, 3, 1'b1);
    run_op("or", 3'b011, 14, 10, 11, 16'h000D, 3, 1'b1);
    run_op("xor", 3'b100, 14, 10, 11, 16'h000C, 3, 1'b1);
    run_op("add_same", 3'b000, 10, 10, 10, 16'd10, 3, 1'b0);

    preload(3, 16'd300);
    preload(5, 16'd7);
    run_op("mul", 3'b111, 9, 3, 5, 16'd2100, 18, 1'b0);
    preload(3, 16'h0100);
    preload(5, 16'h0100);
    run_op("mul_wrap", 3'b111, 9, 3, 5, 16'h0000, 18, 1'b0);

    preload(6, 16'h8001);
    preload(8, 16'd4);
    run_op("shl", 3'b101, 2, 6, 8, 16'h0010, 3, 1'b0);
    run_op("shr", 3'b110, 2, 6, 8, 16'h0800, 3, 1'b0);

    // Continuous valid: second op waits until after WB and sees r12.
    @(negedge clk);
    instr_valid = 1'b1;
    instr_op    = 3'b000;
    instr_rd    = 12;
    instr_rs1   = 10;
    instr_rs2   = 10;
    @(posedge clk);
    #1;
    instr_rd  = 13;
    instr_rs1 = 12;
    instr_rs2 = 12;
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (en) break;
      chk("b2b_busy", instr_ready, 0);
    end
    chk("b2b1_lat", n, 3);
    chk("b2b1_wd", wd, 16'd20);
    @(negedge clk);
    chk("b2b_idle", instr_ready, 1);
    chk("b2b_rf12", rf[12], 16'd20);
    @(posedge clk);
    #1 instr_valid = 1'b0;
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (en) break;
    end
    chk("b2b2_lat", n, 3);
    chk("b2b2_wa", wa, 13);
    chk("b2b2_wd", wd, 16'd40);

    // Reset during MUL EXEC cycle 8 aborts the write.
    preload(4, 16'h1234);
    preload(3, 16'd3);
    preload(5, 16'd5);
    @(negedge clk);
    instr_valid = 1'b1;
    instr_op    = 3'b111;
    instr_rd    = 4;
    instr_rs1   = 3;
    instr_rs2   = 5;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    repeat (9) @(negedge clk);
    chk("abort_busy", instr_ready, 0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_ready", instr_ready, 1);
    chk("abort_en", en, 0);
    chk("abort_done", done, 0);
    chk("abort_carry", carry, 0);
    chk("abort_ra1", ra1, 0);
    chk("abort_ra2", ra2, 0);
    chk("abort_wa", wa, 0);
    chk("abort_wd", wd, 0);
    seen = 0;
    repeat (25) begin
      @(negedge clk);
      if (en) seen++;
    end
    chk("abort_no_en", seen, 0);
    chk("abort_rf4", rf[4], 16'h1234);

    run_op("post_rst", 3'b000, 7, 3, 5, 16'd8, 3, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
